// File: rtl/bimc_pkg.sv
// -----------------------------------------------------------------------------
// bimc_pkg
// Shared types and widths for the Bayesian in-memory-compute job scheduler.
//   - bimc_state_e : scheduler FSM state (IDLE, ISSUE, WAIT, RESP)
//   - bimc_rsp_t   : captured response {id, mean, conf, err}
// The id field is sized for the largest supported requester count (8).
// -----------------------------------------------------------------------------
package bimc_pkg;

  localparam int BIMC_WSEL_W = 2;
  localparam int BIMC_RES_W  = 4;
  localparam int BIMC_ID_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bimc_state_e;

  typedef struct packed {
    logic [BIMC_ID_W-1:0]  id;
    logic [BIMC_RES_W-1:0] mean;
    logic [BIMC_RES_W-1:0] conf;
    logic                  err;
  } bimc_rsp_t;

endpackage

// File: rtl/bimc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bimc_rr_arbiter
// Round-robin arbiter. The grant is combinational: the first set bit of
// req_i searched from the pointer upward with wrap-around. On accept_i the
// pointer moves to one past the granted index.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_i        : request vector
//   accept_i     : grant was taken this cycle, advance the pointer
//   grant_o      : one-hot grant
//   grant_idx_o  : binary index of the granted requester
//   rr_ptr_o     : current search start position
// -----------------------------------------------------------------------------
module bimc_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic [IDX_W-1:0]   rr_ptr_o
);

  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;

  // Rotating priority search starting at the pointer.
  always_comb begin
    int   cand_s;
    logic found_s;
    grant_s     = '0;
    grant_idx_s = '0;
    found_s     = 1'b0;
    cand_s      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found_s && req_i[cand_s]) begin
        found_s         = 1'b1;
        grant_s[cand_s] = 1'b1;
        grant_idx_s     = IDX_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next pointer: one past the granted index, wrapping at NUM_REQ.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_i) begin
      if (grant_idx_s == IDX_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_s + IDX_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant_o     = grant_s;
  assign grant_idx_o = grant_idx_s;
  assign rr_ptr_o    = rr_ptr_q;

endmodule

// File: rtl/bimc_job_scheduler.sv
// -----------------------------------------------------------------------------
// bimc_job_scheduler
// Shares one Bayesian in-memory-compute core among NUM_REQ requesters. A job
// is accepted over a per-requester valid/ready handshake, its operands are
// held in registers for the whole core run, the core is started with a
// one-cycle pulse and its result is returned tagged on a shared response
// channel. One job is in flight at a time.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   req_valid/req_ready            : per-requester handshake (ready one-hot)
//   req_data/req_wsel/req_conf     : packed per-requester operands
//   core_start                     : one-cycle start pulse to the core
//   core_data/core_wsel/core_conf  : registered operands to the core
//   core_mean/core_conf_lvl/done   : core result and completion pulse
//   rsp_valid/rsp_ready            : response handshake
//   rsp_id/rsp_mean/rsp_conf/err   : response fields
//   busy                           : scheduler not idle
// Build option:
//   BIMC_SCHED_TIMEOUT_EN : abort a core run after TIMEOUT cycles in WAIT and
//                           respond with rsp_err=1. Undefined: WAIT is
//                           unbounded and rsp_err is always 0.
// -----------------------------------------------------------------------------
module bimc_job_scheduler
  import bimc_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int WORD_SIZE = 8,
`ifdef BIMC_SCHED_TIMEOUT_EN
  parameter  int TIMEOUT   = 127,
`endif
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
  input  logic [NUM_REQ*BIMC_WSEL_W-1:0] req_wsel,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_conf,
  output logic                           core_start,
  output logic [WORD_SIZE-1:0]           core_data,
  output logic [BIMC_WSEL_W-1:0]         core_wsel,
  output logic [WORD_SIZE-1:0]           core_conf,
  input  logic [BIMC_RES_W-1:0]          core_mean,
  input  logic [BIMC_RES_W-1:0]          core_conf_lvl,
  input  logic                           core_done,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [BIMC_RES_W-1:0]          rsp_mean,
  output logic [BIMC_RES_W-1:0]          rsp_conf,
  output logic                           rsp_err,
  output logic                           busy
);

  bimc_state_e              state_q, state_d;
  logic [WORD_SIZE-1:0]     data_q, data_d;
  logic [BIMC_WSEL_W-1:0]   wsel_q, wsel_d;
  logic [WORD_SIZE-1:0]     conf_q, conf_d;
  logic [ID_W-1:0]          id_q, id_d;
  bimc_rsp_t                rsp_q, rsp_d;
  logic                     start_q, rsp_valid_q, busy_q;
  logic [NUM_REQ-1:0]       grant_s;
  logic [ID_W-1:0]          grant_idx_s;
  logic [ID_W-1:0]          rr_ptr_s;
  logic                     accept_s;
  logic                     id_unused_s;
  logic                     ptr_unused_s;

`ifdef BIMC_SCHED_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  bimc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid),
    .accept_i    (accept_s),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s),
    .rr_ptr_o    (rr_ptr_s)
  );

  // A handshake is any valid request seen while idle; the arbiter picks one.
  assign accept_s = (state_q == ST_IDLE) && (|req_valid);

  // Next-state and capture logic for the job FSM.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    wsel_d  = wsel_q;
    conf_d  = conf_q;
    id_d    = id_q;
    rsp_d   = rsp_q;
`ifdef BIMC_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          data_d  = req_data[int'(grant_idx_s)*WORD_SIZE +: WORD_SIZE];
          wsel_d  = req_wsel[int'(grant_idx_s)*BIMC_WSEL_W +: BIMC_WSEL_W];
          conf_d  = req_conf[int'(grant_idx_s)*WORD_SIZE +: WORD_SIZE];
          id_d    = grant_idx_s;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
`ifdef BIMC_SCHED_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          rsp_d.id   = BIMC_ID_W'(id_q);
          rsp_d.mean = core_mean;
          rsp_d.conf = core_conf_lvl;
          rsp_d.err  = 1'b0;
          state_d    = ST_RESP;
        end
`ifdef BIMC_SCHED_TIMEOUT_EN
        // Last permitted WAIT cycle without done: abort with an error response.
        else if (cnt_q == TO_LAST) begin
          rsp_d.id   = BIMC_ID_W'(id_q);
          rsp_d.mean = {BIMC_RES_W{1'b0}};
          rsp_d.conf = {BIMC_RES_W{1'b0}};
          rsp_d.err  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = ST_WAIT;
        end
`else
        else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and response registers; decoded outputs are registered
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      wsel_q      <= '0;
      conf_q      <= '0;
      id_q        <= '0;
      rsp_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      wsel_q      <= wsel_d;
      conf_q      <= conf_d;
      id_q        <= id_d;
      rsp_q       <= rsp_d;
      start_q     <= (state_d == ST_ISSUE);
      rsp_valid_q <= (state_d == ST_RESP);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

`ifdef BIMC_SCHED_TIMEOUT_EN
  // WAIT-cycle counter for the abort timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Grant is only exposed while idle and out of reset so every output reads
  // 0 during reset even if requesters keep valid high.
  assign req_ready    = ((state_q == ST_IDLE) && rst_n) ? grant_s : '0;
  assign core_start   = start_q;
  assign core_data    = data_q;
  assign core_wsel    = wsel_q;
  assign core_conf    = conf_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_q.id[ID_W-1:0];
  assign rsp_mean     = rsp_q.mean;
  assign rsp_conf     = rsp_q.conf;
  assign rsp_err      = rsp_q.err;
  assign busy         = busy_q;
  assign id_unused_s  = ^rsp_q.id;
  assign ptr_unused_s = ^rr_ptr_s;

endmodule

// File: tb/tb_bimc_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bimc_job_scheduler
// Randomised bench: requesters post jobs at random, a simple core model
// answers each start pulse after a random latency (and sometimes pulses done
// spuriously while the scheduler is idle or responding), and the response
// side stalls at random. A transaction-level reference model tracks the
// scheduler phase, round-robin pointer and expected operands/response.
// One asynchronous reset is injected in the middle of a core run.
// -----------------------------------------------------------------------------
module tb_bimc_job_scheduler;

  localparam int N = 4;
  localparam int W = 8;
`ifdef BIMC_SCHED_TIMEOUT_EN
  localparam int TO      = 20;
  localparam int MAX_LAT = 30;
`else
  localparam int MAX_LAT = 45;
`endif
  localparam int P_IDLE  = 0;
  localparam int P_ISSUE = 1;
  localparam int P_WAIT  = 2;
  localparam int P_RESP  = 3;
  localparam int N_CYC   = 3000;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic [N*2-1:0] req_wsel;
  logic [N*W-1:0] req_conf;
  logic           core_start;
  logic [W-1:0]   core_data;
  logic [1:0]     core_wsel;
  logic [W-1:0]   core_conf;
  logic [3:0]     core_mean;
  logic [3:0]     core_conf_lvl;
  logic           core_done;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [3:0]     rsp_mean;
  logic [3:0]     rsp_conf;
  logic           rsp_err;
  logic           busy;

  bimc_job_scheduler #(
    .NUM_REQ   (N),
`ifdef BIMC_SCHED_TIMEOUT_EN
    .TIMEOUT   (TO),
`endif
    .WORD_SIZE (W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .req_wsel      (req_wsel),
    .req_conf      (req_conf),
    .core_start    (core_start),
    .core_data     (core_data),
    .core_wsel     (core_wsel),
    .core_conf     (core_conf),
    .core_mean     (core_mean),
    .core_conf_lvl (core_conf_lvl),
    .core_done     (core_done),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_mean      (rsp_mean),
    .rsp_conf      (rsp_conf),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Round-robin pick: first valid requester from ptr upward, wrapping.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int ptr);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) begin
        r[(ptr + k) % N] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // Requester-side job storage.
  bit         pend [N];
  logic [7:0] jd   [N];
  logic [1:0] jw   [N];
  logic [7:0] jc   [N];

  // Reference model state.
  int         m_phase;
  int         m_ptr;
  int         m_id;
  int         m_wcnt;
  logic [7:0] m_data;
  logic [1:0] m_wsel;
  logic [7:0] m_conf;
  logic [3:0] m_mean;
  logic [3:0] m_cl;
  logic       m_err;
  int         core_cnt;
  bit         did_rst;
  int         n_jobs;
  int         n_resp;

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  32'(req_ready),  32'd0);
    check({tag, "_core_start"}, 32'(core_start), 32'd0);
    check({tag, "_core_data"},  32'(core_data),  32'd0);
    check({tag, "_core_wsel"},  32'(core_wsel),  32'd0);
    check({tag, "_core_conf"},  32'(core_conf),  32'd0);
    check({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    check({tag, "_rsp_id"},     32'(rsp_id),     32'd0);
    check({tag, "_rsp_mean"},   32'(rsp_mean),   32'd0);
    check({tag, "_rsp_conf"},   32'(rsp_conf),   32'd0);
    check({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  initial begin
    logic [N-1:0] exp_rdy;
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    req_valid     = '0;
    req_data      = '0;
    req_wsel      = '0;
    req_conf      = '0;
    core_mean     = 4'd0;
    core_conf_lvl = 4'd0;
    core_done     = 1'b0;
    rsp_ready     = 1'b0;
    m_phase       = P_IDLE;
    m_ptr         = 0;
    m_id          = 0;
    m_wcnt        = 0;
    m_data        = 8'd0;
    m_wsel        = 2'd0;
    m_conf        = 8'd0;
    m_mean        = 4'd0;
    m_cl          = 4'd0;
    m_err         = 1'b0;
    core_cnt      = 0;
    did_rst       = 1'b0;
    n_jobs        = 0;
    n_resp        = 0;

    // All four requesters start with a job so the first grants rotate 0..3.
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      jd[i]   = 8'($urandom_range(0, 255));
      jw[i]   = 2'($urandom_range(0, 3));
      jc[i]   = 8'($urandom_range(0, 255));
    end

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);

      // Core model: done after the random latency, or a stray done when
      // the scheduler is not waiting for one.
      core_done     = 1'b0;
      core_mean     = 4'd0;
      core_conf_lvl = 4'd0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done     = 1'b1;
          core_mean     = 4'($urandom_range(0, 15));
          core_conf_lvl = 4'($urandom_range(0, 15));
        end
      end else if ((m_phase == P_IDLE || m_phase == P_RESP) && $urandom_range(0, 19) == 0) begin
        core_done     = 1'b1;
        core_mean     = 4'($urandom_range(1, 15));
        core_conf_lvl = 4'($urandom_range(1, 15));
      end

      // Requesters post new jobs at random and hold them until accepted.
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          jd[i]   = 8'($urandom_range(0, 255));
          jw[i]   = 2'($urandom_range(0, 3));
          jc[i]   = 8'($urandom_range(0, 255));
        end
        req_valid[i]          = pend[i];
        req_data[i*W +: W]    = jd[i];
        req_wsel[i*2 +: 2]    = jw[i];
        req_conf[i*W +: W]    = jc[i];
      end

      // Response side: periodic long stalls, otherwise random acceptance.
      if ((cyc % 200) < 15) begin
        rsp_ready = 1'b0;
      end else begin
        rsp_ready = ($urandom_range(0, 3) == 0);
      end

      #1;
      exp_rdy = (m_phase == P_IDLE) ? rr_pick(req_valid, m_ptr) : '0;
      check("req_ready",  32'(req_ready),  32'(exp_rdy));
      check("core_start", 32'(core_start), 32'(m_phase == P_ISSUE));
      check("busy",       32'(busy),       32'(m_phase != P_IDLE));
      check("rsp_valid",  32'(rsp_valid),  32'(m_phase == P_RESP));
      check("core_data",  32'(core_data),  32'(m_data));
      check("core_wsel",  32'(core_wsel),  32'(m_wsel));
      check("core_conf",  32'(core_conf),  32'(m_conf));
      if (m_phase == P_RESP) begin
        check("rsp_id",   32'(rsp_id),   32'(m_id));
        check("rsp_mean", 32'(rsp_mean), 32'(m_mean));
        check("rsp_conf", 32'(rsp_conf), 32'(m_cl));
        check("rsp_err",  32'(rsp_err),  32'(m_err));
      end

      // Asynchronous reset once, in the middle of a core run.
      if (!did_rst && cyc > 1000 && m_phase == P_WAIT) begin
        #2;
        rst_n     = 1'b0;
        req_valid = '0;
        core_done = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        m_phase  = P_IDLE;
        m_ptr    = 0;
        m_data   = 8'd0;
        m_wsel   = 2'd0;
        m_conf   = 8'd0;
        core_cnt = 0;
        did_rst  = 1'b1;
        continue;
      end

      // Core model reacts to the start pulse it just saw.
      if (core_start) begin
        core_cnt = $urandom_range(1, MAX_LAT);
      end

      // Reference model advance for the coming rising edge.
      case (m_phase)
        P_IDLE: begin
          if (|req_valid) begin
            for (int i = 0; i < N; i++) begin
              if (exp_rdy[i]) begin
                m_id = i;
              end
            end
            m_data  = jd[m_id];
            m_wsel  = jw[m_id];
            m_conf  = jc[m_id];
            pend[m_id] = 1'b0;
            m_ptr   = (m_id + 1) % N;
            m_phase = P_ISSUE;
            n_jobs++;
          end
        end
        P_ISSUE: begin
          m_wcnt  = 0;
          m_phase = P_WAIT;
        end
        P_WAIT: begin
          if (core_done) begin
            m_mean  = core_mean;
            m_cl    = core_conf_lvl;
            m_err   = 1'b0;
            m_phase = P_RESP;
          end else begin
            m_wcnt++;
`ifdef BIMC_SCHED_TIMEOUT_EN
            if (m_wcnt == TO) begin
              m_mean  = 4'd0;
              m_cl    = 4'd0;
              m_err   = 1'b1;
              m_phase = P_RESP;
            end
`endif
          end
        end
        P_RESP: begin
          if (rsp_ready) begin
            m_phase = P_IDLE;
            n_resp++;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end

    // Progress sanity: the run must have completed a reasonable number of jobs.
    check("jobs_progress", 32'(n_resp > 20), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bimc_job_scheduler.md
# bimc_job_scheduler

Round-robin job scheduler that shares one Bayesian in-memory-compute core among `NUM_REQ` requesters. It accepts a job (input vector, weight word select, confidence pattern) over a per-requester valid/ready handshake and holds the operands stable for the core's whole sampling run. It pulses the core's `start`, waits for its `done` pulse, and returns the tagged result on a single shared response channel. It sits between the host-side request fabric and the core.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WORD_SIZE`, 8: operand width; must match the core.
- `TIMEOUT`, 127: cycles allowed in WAIT before abort (only with `BIMC_SCHED_TIMEOUT_EN`).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in NUM_REQ: per-requester job valid.
- `req_ready` out NUM_REQ: one-hot grant/accept.
- `req_data` in NUM_REQ*WORD_SIZE: input vectors, requester i at slice i.
- `req_wsel` in NUM_REQ*2: weight word selects.
- `req_conf` in NUM_REQ*WORD_SIZE: confidence patterns.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_data` out WORD_SIZE: registered operand to the core.
- `core_wsel` out 2: registered operand to the core.
- `core_conf` out WORD_SIZE: registered operand to the core.
- `core_mean` in 4: core mean result.
- `core_conf_lvl` in 4: core confidence level.
- `core_done` in 1: core one-cycle done pulse.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out clog2(NUM_REQ): requester index.
- `rsp_mean` out 4: captured mean.
- `rsp_conf` out 4: captured confidence.
- `rsp_err` out 1: timeout abort flag.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready` is the combinational one-hot round-robin grant over `req_valid`, searched from `rr_ptr` upward with wrap. On handshake:
  - capture the operands and the granted index,
  - set `rr_ptr` to (granted index + 1) mod NUM_REQ,
  - go to ISSUE.
- IDLE with no `req_valid` bits set: stay in IDLE; `rr_ptr` is unchanged.
- ISSUE: `core_start`=1 for exactly one cycle, then go to WAIT.
- WAIT: on `core_done`=1, capture `core_mean` and `core_conf_lvl`, set `rsp_err`=0, go to RESP.
- RESP: hold `rsp_valid`=1 with stable fields until `rsp_ready`=1, then go to IDLE. Requests stay blocked during RESP.
- `req_ready` is 0 in every state except IDLE. Operand registers change only on an accepted handshake.
- `core_done` outside WAIT is ignored.
- Reset mid-job: everything returns to reset values immediately. The pending job is dropped and no response is issued.
- Reset values: all outputs 0, `rr_ptr`=0, state=IDLE.

## Timing
- Handshake in cycle T: ISSUE at T+1 (`core_start` high), WAIT from T+2.
- With the core's 8-sample run, `core_done` arrives roughly 43 cycles after the start pulse.
- `core_done` sampled at cycle D: `rsp_valid` high at D+1.
- Earliest next grant is the cycle after `rsp_ready`. Next `core_start` is at least 3 cycles after `core_done`, so the core is guaranteed back in IDLE.
- Throughput: one job in flight. Back-to-back jobs from different requesters are granted in strict rotation.

## Configuration
- `BIMC_SCHED_TIMEOUT_EN` defined:
  - an 8-bit counter clears on entering WAIT and increments each WAIT cycle;
  - on reaching `TIMEOUT` without `core_done`, go to RESP with `rsp_err`=1, `rsp_mean`=0, `rsp_conf`=0;
  - a late `core_done` after the abort is ignored.
- `BIMC_SCHED_TIMEOUT_EN` undefined: no counter, `rsp_err` tied 0, WAIT lasts indefinitely.

## Structure
- Shared package `bimc_pkg`:
  - FSM state enum (2 bits),
  - `BIMC_WSEL_W`=2, `BIMC_RES_W`=4,
  - result struct {id, mean, conf, err}.
- One sub-module, `bimc_rr_arbiter`:
  - parameterised on NUM_REQ,
  - owns `rr_ptr` and the one-hot grant,
  - pointer update on an `accept` input.

## Test plan
- Single job: requester 2, data 8'hFF, wsel 1, conf 8'h00; model core returns mean 5, conf 15 → one `core_start` pulse one cycle after the handshake; `rsp_id`=2, `rsp_mean`=5, `rsp_conf`=15, `rsp_err`=0.
- All four `req_valid` held high for four jobs, `rr_ptr` starting at 0 → grant order 0,1,2,3, then 0 again.
- `rsp_ready` held low for 10 cycles → `rsp_valid` and all fields stable, `req_ready`=0 throughout, accept on the first `rsp_ready` high.
- `rst_n` asserted during WAIT → all outputs 0 asynchronously; after release, a fresh job completes normally with no stale response.
- With the macro: `TIMEOUT`=20, model core never pulses done → `rsp_err`=1 with mean/conf 0 exactly 20 WAIT cycles after entry; a late `core_done` produces no second response.
- `core_done` pulsed while IDLE → ignored, no `rsp_valid`.
